// File: rtl/epp_rfs_bridge_if.sv
// Register-file side of the EPP bridge: request pulses, write word and completion handshake.
interface epp_rfs_bridge_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] rfs_address;
    logic [DATA_W-1:0] rfs_write_data;
    logic              rfs_write_en;
    logic              rfs_read_en;
    logic [DATA_W-1:0] rfs_read_data;
    logic              rfs_access_complete;
    logic              rfs_invalid_address;

    modport master (
        output rfs_address, rfs_write_data, rfs_write_en, rfs_read_en,
        input  rfs_read_data, rfs_access_complete, rfs_invalid_address
    );

    modport slave (
        input  rfs_address, rfs_write_data, rfs_write_en, rfs_read_en,
        output rfs_read_data, rfs_access_complete, rfs_invalid_address
    );
endinterface

// File: rtl/epp_rfs_bridge.sv
// EPP slave to RFS register-file bridge with LSB-first multi-byte words and a sticky error flag.
// Optional RFS watchdog is enabled by defining EPP_TIMEOUT_EN.
module epp_rfs_bridge #(
    parameter int RFS_ADDR_W     = 6,
    parameter int RFS_DATA_W     = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int AUTO_INC       = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        res,
    inout  wire  [7:0]  EPP_DB,
    input  logic        EPP_ASTB,
    input  logic        EPP_DSTB,
    input  logic        EPP_WRITE,
    output logic        EPP_WAIT,
    epp_rfs_bridge_if.master rfs
);
    localparam int BYTES = RFS_DATA_W / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    typedef enum logic [9:0] {
        IDLE    = 10'b00_0000_0001,
        ADDR_WR = 10'b00_0000_0010,
        ADDR_RD = 10'b00_0000_0100,
        WR_BYTE = 10'b00_0000_1000,
        WR_REQ  = 10'b00_0001_0000,
        WR_WAIT = 10'b00_0010_0000,
        RD_REQ  = 10'b00_0100_0000,
        RD_WAIT = 10'b00_1000_0000,
        RD_BYTE = 10'b01_0000_0000,
        ACK     = 10'b10_0000_0000
    } state_t;

    state_t state, next_state;

    logic [SYNC_STAGES-1:0]      astb_sync, dstb_sync, write_sync;
    logic [SYNC_STAGES-1:0][7:0] db_sync;
    logic                        astb, dstb, host_read;
    logic [7:0]                  db;

    logic [RFS_ADDR_W-1:0] address;
    logic [IDX_W-1:0]      byte_idx;
    logic                  err;
    logic [RFS_DATA_W-1:0] shadow;
    logic [7:0]            db_hold;
    logic                  ack_addr, ack_read;

    logic       last_byte, in_xfer, done, expired, finish, bad_done;
    logic [7:0] status_byte, shadow_byte, db_out;
    logic       db_drive, write_en, read_en;

    // Strobes reset to their inactive (high) level so the FSM never sees a phantom cycle after reset.
    always_ff @(posedge clk) begin
        if (res) begin
            astb_sync  <= '1;
            dstb_sync  <= '1;
            write_sync <= '0;
            db_sync    <= '0;
        end else begin
            astb_sync  <= {astb_sync[SYNC_STAGES-2:0], EPP_ASTB};
            dstb_sync  <= {dstb_sync[SYNC_STAGES-2:0], EPP_DSTB};
            write_sync <= {write_sync[SYNC_STAGES-2:0], EPP_WRITE};
            db_sync    <= {db_sync[SYNC_STAGES-2:0], EPP_DB};
        end
    end

    assign astb      = astb_sync[SYNC_STAGES-1];
    assign dstb      = dstb_sync[SYNC_STAGES-1];
    assign host_read = write_sync[SYNC_STAGES-1];
    assign db        = db_sync[SYNC_STAGES-1];

    assign last_byte   = (byte_idx == LAST_IDX);
    assign shadow_byte = shadow[{byte_idx, 3'b000} +: 8];
    assign in_xfer     = (state == WR_REQ) || (state == WR_WAIT) ||
                         (state == RD_REQ) || (state == RD_WAIT);
    assign done        = in_xfer && rfs.rfs_access_complete;

`ifdef EPP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (res || state == WR_REQ || state == RD_REQ)
            wd_cnt <= '0;
        else if (state == WR_WAIT || state == RD_WAIT)
            wd_cnt <= wd_cnt + 1'b1;
    end

    assign expired = ((state == WR_WAIT) || (state == RD_WAIT)) && !rfs.rfs_access_complete &&
                     (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign expired = 1'b0;
`endif

    assign finish   = done || expired;
    assign bad_done = (done && rfs.rfs_invalid_address) || expired;

    always_comb begin
        status_byte    = 8'(address);
        status_byte[7] = err;
    end

    always_ff @(posedge clk) begin
        if (res) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        write_en   = 1'b0;
        read_en    = 1'b0;
        EPP_WAIT   = 1'b0;
        db_drive   = 1'b0;
        db_out     = db_hold;
        unique case (state)
            IDLE: begin
                if (!astb)
                    next_state = host_read ? ADDR_RD : ADDR_WR;
                else if (!dstb)
                    next_state = !host_read ? WR_BYTE : ((byte_idx == '0) ? RD_REQ : RD_BYTE);
            end
            ADDR_WR: next_state = ACK;
            ADDR_RD: begin
                db_out     = status_byte;
                db_drive   = host_read;
                next_state = ACK;
            end
            WR_BYTE: next_state = last_byte ? WR_REQ : ACK;
            WR_REQ: begin
                write_en   = 1'b1;
                next_state = finish ? ACK : WR_WAIT;
            end
            WR_WAIT: if (finish) next_state = ACK;
            RD_REQ: begin
                read_en    = 1'b1;
                next_state = finish ? RD_BYTE : RD_WAIT;
            end
            RD_WAIT: if (finish) next_state = RD_BYTE;
            RD_BYTE: begin
                db_out     = shadow_byte;
                db_drive   = host_read;
                next_state = ACK;
            end
            ACK: begin
                EPP_WAIT = 1'b1;
                db_drive = host_read && ack_read;
                if (ack_addr ? astb : dstb) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            address  <= '0;
            byte_idx <= '0;
            err      <= 1'b0;
            shadow   <= '0;
            db_hold  <= '0;
            ack_addr <= 1'b0;
            ack_read <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!astb || !dstb) begin
                        ack_addr <= !astb;
                        ack_read <= host_read;
                    end
                end
                ADDR_WR: begin
                    address  <= db[RFS_ADDR_W-1:0];
                    byte_idx <= '0;
                    err      <= db[7];
                end
                ADDR_RD: db_hold <= status_byte;
                WR_BYTE: begin
                    shadow[{byte_idx, 3'b000} +: 8] <= db;
                    if (!last_byte) byte_idx <= byte_idx + 1'b1;
                end
                WR_REQ, WR_WAIT: begin
                    if (finish) begin
                        byte_idx <= '0;
                        if (AUTO_INC != 0) address <= address + 1'b1;
                        if (bad_done) err <= 1'b1;
                    end
                end
                RD_REQ, RD_WAIT: begin
                    if (finish) begin
                        shadow <= bad_done ? '1 : rfs.rfs_read_data;
                        if (bad_done) err <= 1'b1;
                    end
                end
                RD_BYTE: begin
                    db_hold <= shadow_byte;
                    if (last_byte) begin
                        byte_idx <= '0;
                        if (AUTO_INC != 0) address <= address + 1'b1;
                    end else begin
                        byte_idx <= byte_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign EPP_DB             = db_drive ? db_out : 8'bz;
    assign rfs.rfs_address    = address;
    assign rfs.rfs_write_data = shadow;
    assign rfs.rfs_write_en   = write_en;
    assign rfs.rfs_read_en    = read_en;
endmodule

// File: tb/tb_epp_rfs_bridge.sv
// Directed bench for epp_rfs_bridge: EPP host tasks plus a small RFS responder with programmable latency.
module tb_epp_rfs_bridge;
    logic clk = 1'b0;
    logic res;
    always #5 clk = ~clk;

    wire  [7:0] EPP_DB;
    logic [7:0] host_db;
    logic       host_drive;
    logic       astb_n, dstb_n, epp_write, epp_wait;
    assign EPP_DB = host_drive ? host_db : 8'bz;

    epp_rfs_bridge_if #(.ADDR_W(6), .DATA_W(32)) rfs_if ();

    epp_rfs_bridge #(
        .RFS_ADDR_W(6), .RFS_DATA_W(32), .SYNC_STAGES(2), .AUTO_INC(1), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .res(res), .EPP_DB(EPP_DB), .EPP_ASTB(astb_n), .EPP_DSTB(dstb_n),
        .EPP_WRITE(epp_write), .EPP_WAIT(epp_wait), .rfs(rfs_if.master)
    );

    int total = 0;
    int bad   = 0;

    // RFS responder: completes each request rsp_lat cycles later (0 = same cycle as the pulse)
    int          rsp_lat     = 1;
    logic        rsp_on      = 1'b1;
    logic        rsp_invalid = 1'b0;
    logic [31:0] rsp_data    = 32'h0;
    logic        pending     = 1'b0;
    int          wait_cnt    = 0;
    int          wr_pulses   = 0;
    int          rd_pulses   = 0;
    logic [5:0]  last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    logic [5:0]  last_rd_addr = '0;
    logic        req;

    assign req = rfs_if.rfs_write_en | rfs_if.rfs_read_en;
    assign rfs_if.rfs_access_complete = rsp_on && (((rsp_lat == 0) && req) || (pending && wait_cnt == 0));
    assign rfs_if.rfs_invalid_address = rsp_invalid;
    assign rfs_if.rfs_read_data       = rsp_data;

    always @(posedge clk) begin
        if (rfs_if.rfs_write_en) begin
            wr_pulses    <= wr_pulses + 1;
            last_wr_addr <= rfs_if.rfs_address;
            last_wr_data <= rfs_if.rfs_write_data;
        end
        if (rfs_if.rfs_read_en) begin
            rd_pulses    <= rd_pulses + 1;
            last_rd_addr <= rfs_if.rfs_address;
        end
        if (req && rsp_lat > 0) begin
            pending  <= 1'b1;
            wait_cnt <= rsp_lat - 1;
        end else if (pending) begin
            if (wait_cnt == 0) pending <= 1'b0;
            else               wait_cnt <= wait_cnt - 1;
        end
    end

    // One complete EPP host cycle; lat counts falling edges from strobe assertion to EPP_WAIT high.
    task automatic epp_cycle(input bit is_addr, input bit is_read, input logic [7:0] wdata,
                             output logic [7:0] rdata, output int lat);
        int n;
        epp_write  = is_read;
        host_drive = !is_read;
        host_db    = wdata;
        @(negedge clk);
        if (is_addr) astb_n = 1'b0;
        else         dstb_n = 1'b0;
        lat = 0;
        while (!epp_wait && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!epp_wait) begin
            total++; bad++;
            $display("[TB] FAIL wait_rise: EPP_WAIT=%0b after %0d cycles, required 1", epp_wait, lat);
        end
        rdata  = EPP_DB;
        astb_n = 1'b1;
        dstb_n = 1'b1;
        n = 0;
        while (epp_wait && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (epp_wait) begin
            total++; bad++;
            $display("[TB] FAIL wait_fall: EPP_WAIT=%0b after release, required 0", epp_wait);
        end
        host_drive = 1'b0;
        epp_write  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [7:0] rd;
        int lat;
        res = 1'b1;
        repeat (2) @(negedge clk);
        res = 1'b0;
        @(negedge clk);
        total++; if (epp_wait !== 1'b0) begin bad++; $display("[TB] FAIL reset_wait: got %0b want 0", epp_wait); end
        total++; if (rfs_if.rfs_write_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_wren: got %0b want 0", rfs_if.rfs_write_en); end
        total++; if (rfs_if.rfs_read_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_rden: got %0b want 0", rfs_if.rfs_read_en); end
        total++; if (rfs_if.rfs_address !== 6'h00) begin bad++; $display("[TB] FAIL reset_addr: got %h want 00", rfs_if.rfs_address); end
        total++; if (rfs_if.rfs_write_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_wdata: got %h want 0", rfs_if.rfs_write_data); end
        epp_cycle(1, 1, 8'h00, rd, lat);
        total++; if (rd !== 8'h00) begin bad++; $display("[TB] FAIL reset_status: got %h want 00", rd); end
    endtask

    task automatic test_addr;
        logic [7:0] rd;
        int lat;
        epp_cycle(1, 0, 8'h05, rd, lat);
        total++; if (lat < 3 || lat > 5) begin bad++; $display("[TB] FAIL addr_latency: got %0d want 3..5", lat); end
        total++; if (rfs_if.rfs_address !== 6'h05) begin bad++; $display("[TB] FAIL addr_out: got %h want 05", rfs_if.rfs_address); end
        epp_cycle(1, 1, 8'h00, rd, lat);
        total++; if (rd !== 8'h05) begin bad++; $display("[TB] FAIL addr_readback: got %h want 05", rd); end
        total++; if (epp_wait !== 1'b0) begin bad++; $display("[TB] FAIL addr_wait_idle: got %0b want 0", epp_wait); end
    endtask

    task automatic test_word_write;
        logic [7:0] rd;
        int lat, wr0;
        logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        rsp_lat = 2;
        epp_cycle(1, 0, 8'h03, rd, lat);
        wr0 = wr_pulses;
        for (int i = 0; i < 3; i++) epp_cycle(0, 0, bytes[i], rd, lat);
        total++; if (wr_pulses - wr0 !== 0) begin bad++; $display("[TB] FAIL wr_early: got %0d pulses want 0", wr_pulses - wr0); end
        epp_cycle(0, 0, bytes[3], rd, lat);
        total++; if (wr_pulses - wr0 !== 1) begin bad++; $display("[TB] FAIL wr_pulses: got %0d want 1", wr_pulses - wr0); end
        total++; if (last_wr_data !== 32'h44332211) begin bad++; $display("[TB] FAIL wr_data: got %h want 44332211", last_wr_data); end
        total++; if (last_wr_addr !== 6'h03) begin bad++; $display("[TB] FAIL wr_addr: got %h want 03", last_wr_addr); end
        epp_cycle(1, 1, 8'h00, rd, lat);
        total++; if (rd !== 8'h04) begin bad++; $display("[TB] FAIL wr_autoinc: got %h want 04", rd); end
    endtask

    task automatic test_word_read;
        logic [7:0] rd;
        int lat, rd0;
        logic [7:0] expect_b [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        rsp_lat  = 5;
        rsp_data = 32'hDEADBEEF;
        epp_cycle(1, 0, 8'h02, rd, lat);
        rd0 = rd_pulses;
        for (int i = 0; i < 4; i++) begin
            epp_cycle(0, 1, 8'h00, rd, lat);
            if (i == 0) begin
                total++; if (lat < 9) begin bad++; $display("[TB] FAIL rd_holdoff: got %0d cycles want >=9", lat); end
            end
            total++; if (rd !== expect_b[i]) begin bad++; $display("[TB] FAIL rd_byte%0d: got %h want %h", i, rd, expect_b[i]); end
        end
        total++; if (rd_pulses - rd0 !== 1) begin bad++; $display("[TB] FAIL rd_pulses: got %0d want 1", rd_pulses - rd0); end
        total++; if (last_rd_addr !== 6'h02) begin bad++; $display("[TB] FAIL rd_addr: got %h want 02", last_rd_addr); end
        epp_cycle(1, 1, 8'h00, rd, lat);
        total++; if (rd !== 8'h03) begin bad++; $display("[TB] FAIL rd_autoinc: got %h want 03", rd); end
    endtask

    task automatic test_invalid;
        logic [7:0] rd;
        int lat;
        rsp_lat     = 1;
        rsp_invalid = 1'b1;
        rsp_data    = 32'h12345678;
        epp_cycle(1, 0, 8'h07, rd, lat);
        epp_cycle(0, 1, 8'h00, rd, lat);
        total++; if (rd !== 8'hFF) begin bad++; $display("[TB] FAIL inv_byte: got %h want FF", rd); end
        rsp_invalid = 1'b0;
        epp_cycle(1, 1, 8'h00, rd, lat);
        total++; if (rd !== 8'h87) begin bad++; $display("[TB] FAIL inv_err_set: got %h want 87", rd); end
        epp_cycle(1, 0, 8'h01, rd, lat);
        epp_cycle(1, 1, 8'h00, rd, lat);
        total++; if (rd !== 8'h01) begin bad++; $display("[TB] FAIL inv_err_clear: got %h want 01", rd); end
    endtask

    task automatic test_wrap;
        logic [7:0] rd;
        int lat, wr0;
        rsp_lat = 0;
        epp_cycle(1, 0, 8'h3F, rd, lat);
        wr0 = wr_pulses;
        for (int i = 0; i < 4; i++) epp_cycle(0, 0, 8'(8'hA0 + i), rd, lat);
        total++; if (wr_pulses - wr0 !== 1) begin bad++; $display("[TB] FAIL wrap_pulses: got %0d want 1", wr_pulses - wr0); end
        total++; if (last_wr_data !== 32'hA3A2A1A0) begin bad++; $display("[TB] FAIL wrap_data: got %h want A3A2A1A0", last_wr_data); end
        total++; if (last_wr_addr !== 6'h3F) begin bad++; $display("[TB] FAIL wrap_wr_addr: got %h want 3F", last_wr_addr); end
        epp_cycle(1, 1, 8'h00, rd, lat);
        total++; if (rd !== 8'h00) begin bad++; $display("[TB] FAIL wrap_addr: got %h want 00", rd); end
    endtask

    task automatic test_same_cycle_read;
        logic [7:0] rd;
        int lat;
        logic [7:0] expect_b [4] = '{8'h70, 8'h1E, 8'hC3, 8'hA5};
        rsp_lat  = 0;
        rsp_data = 32'hA5C31E70;
        epp_cycle(1, 0, 8'h10, rd, lat);
        for (int i = 0; i < 4; i++) begin
            epp_cycle(0, 1, 8'h00, rd, lat);
            total++; if (rd !== expect_b[i]) begin bad++; $display("[TB] FAIL same_cycle_byte%0d: got %h want %h", i, rd, expect_b[i]); end
        end
    endtask

    task automatic test_reset_abort;
        logic [7:0] rd;
        int lat;
        rsp_lat = 1;
        epp_cycle(1, 0, 8'h08, rd, lat);
        epp_cycle(0, 0, 8'hAA, rd, lat);
        epp_cycle(0, 0, 8'hBB, rd, lat);
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 1; i <= 4; i++) epp_cycle(0, 0, 8'(i), rd, lat);
        total++; if (last_wr_data !== 32'h04030201) begin bad++; $display("[TB] FAIL abort_data: got %h want 04030201", last_wr_data); end
        total++; if (last_wr_addr !== 6'h00) begin bad++; $display("[TB] FAIL abort_addr: got %h want 00", last_wr_addr); end
    endtask

`ifdef EPP_TIMEOUT_EN
    task automatic test_timeout;
        logic [7:0] rd;
        int lat;
        rsp_on = 1'b0;
        epp_cycle(1, 0, 8'h04, rd, lat);
        epp_cycle(0, 1, 8'h00, rd, lat);
        total++; if (lat < 18 || lat > 26) begin bad++; $display("[TB] FAIL to_latency: got %0d want 18..26", lat); end
        total++; if (rd !== 8'hFF) begin bad++; $display("[TB] FAIL to_byte: got %h want FF", rd); end
        epp_cycle(1, 1, 8'h00, rd, lat);
        total++; if (rd !== 8'h84) begin bad++; $display("[TB] FAIL to_err: got %h want 84", rd); end
        rsp_on = 1'b1;
    endtask
`endif

    initial begin
        res        = 1'b1;
        astb_n     = 1'b1;
        dstb_n     = 1'b1;
        epp_write  = 1'b0;
        host_drive = 1'b0;
        host_db    = 8'h00;
        test_reset;
        test_addr;
        test_word_write;
        test_word_read;
        test_invalid;
        test_wrap;
        test_same_cycle_read;
        test_reset_abort;
`ifdef EPP_TIMEOUT_EN
        test_timeout;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "[TB] timeout");
    end
endmodule
